rand_seeder: RTL
================

// Module: rand_seeder
// PURPOSE
//  Wishbone bus master that initialises every stream of the multi-stream RNG
//  peripheral after boot or on software request. For each stream it writes
//  the stream select, a nonzero m_z seed and a nonzero m_w seed, drawn from
//  an internal 32-bit LFSR. It sits directly upstream of the RNG slave on the
//  SoC bus; the slave needs a rising WE edge per write, so every write is
//  separated by a bus-idle gap.
// PARAMETERS
//  RAND_ADDR  32'hFDFF4000  base address of RNG slave (stream +04, m_z +08, m_w +0C)
//  NSTREAMS   1024          streams to seed (1..1024); stream index is 10 bits
//  GAP        2             idle cycles (cyc/stb/we low) after each ack, >=1
//  TIMEOUT    255           max cycles cyc_o may wait for ack_i before abort
//  LFSR_INIT  32'hACE12468  LFSR base value, XORed with seed_i on start
// PORTS
//  clk_i    in   1   clock
//  rst_i    in   1   synchronous active-high reset
//  start_i  in   1   begin seeding, sampled only in IDLE or ERR
//  seed_i   in   32  entropy mixed into LFSR at start
//  busy_o   out  1   sequence in progress
//  done_o   out  1   one-cycle pulse on successful completion
//  err_o    out  1   sticky timeout flag, cleared by next start or reset
//  cyc_o    out  1   wishbone cycle
//  stb_o    out  1   wishbone strobe, always equal to cyc_o
//  we_o     out  1   wishbone write enable, always equal to cyc_o
//  sel_o    out  4   byte selects, 4'hF while cyc_o, else 0
//  adr_o    out  32  RAND_ADDR + offset while cyc_o, else 0
//  dat_o    out  32  write data while cyc_o, else 0
//  ack_i    in   1   wishbone acknowledge from slave
// BEHAVIOUR
//  - All outputs are registered. On reset every output is 0, FSM=IDLE,
//    stream=0, lfsr=LFSR_INIT, timeout counter=0. Reset mid-sequence aborts
//    it and returns to IDLE at the next edge, with no further bus activity.
//  - FSM states: IDLE, WR, GAP, DONE, ERR.
//  - IDLE/ERR + start_i: lfsr <= LFSR_INIT^seed_i. If the result is 0, lfsr <= 1.
//    err_o<=0, busy_o<=1, enter WR with op=STREAM, stream=0. cyc_o is high
//    on the following cycle.
//  - start_i is ignored while busy_o is high.
//  - Op sequence per stream s:
//    1. STREAM: adr +04, dat={22'h0,s}.
//    2. Z: adr +08, dat=lfsr.
//    3. W: adr +0C, dat=lfsr.
//    After the last stream, one final STREAM write with dat=0 restores the
//    stream select. Total writes = 3*NSTREAMS+1.
//  - LFSR: Galois form, taps 32'h80200003, shift right. It steps once after
//    each Z or W ack. A seed value of 0 is replaced by 32'h1 on the bus.
//  - WR: cyc/stb/we/sel/adr/dat are held stable until ack_i is sampled high.
//    At that edge all bus outputs go to 0 and the FSM enters GAP. ack_i
//    outside WR is ignored.
//  - GAP: hold for GAP cycles with the bus idle, then advance the op or stream
//    and return to WR. After the final write, enter DONE instead.
//  - DONE: done_o=1 and busy_o=0 for one cycle, then IDLE.
//  - Timeout: the counter increments on each WR cycle without ack and clears
//    on entering WR. If it reaches TIMEOUT, the bus drops next edge and the
//    FSM enters ERR with err_o=1 and busy_o=0. An ack in the same cycle as
//    the limit counts as success.
//  - The stream counter wraps only through the final write, never past NSTREAMS-1.
// TESTING (bench slave model acks 2 cycles after stb; NSTREAMS=4, GAP=2)
//  1. Reset, then start_i with seed_i=0.
//     -> 13 writes: adr FDFF4004/08/0C repeated 4x, then FDFF4004 with dat 0.
//     -> First Z dat = 32'hACE12468. done_o pulses once. busy_o low after.
//  2. Check bus gaps.
//     -> Between consecutive acks, cyc_o and we_o are low for exactly 2
//        cycles. No write is missed by the RNG slave: read-back of stream
//        reg = 0 at the end.
//  3. Slave never acks, TIMEOUT=16.
//     -> cyc_o is high exactly 16 cycles, then drops. err_o=1, done_o never
//        pulses. A new start_i clears err_o and restarts at stream 0.
//  4. seed_i=32'hACE12468 (LFSR_INIT^seed_i = 0).
//     -> LFSR is forced to 1. No Z/W dat is ever 0. Sequence matches the
//        golden LFSR model.
//  5. Assert rst_i during the W write of stream 2.
//     -> Next cycle all outputs are 0. A following start repeats the exact
//        scenario 1 trace.
//  6. Pulse start_i mid-sequence.
//     -> Ignored: write count remains 13 and the LFSR sequence is unchanged.

Source files
------------

// File: rtl/rand_seeder.sv
// rand_seeder: wishbone master writing stream select plus nonzero LFSR m_z/m_w seeds to every RNG stream, one idle gap after each ack
module rand_seeder #(
  parameter logic [31:0] RAND_ADDR = 32'hFDFF4000,
  parameter int NSTREAMS = 1024,
  parameter int GAP = 2,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] LFSR_INIT = 32'hACE12468
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [9:0] LAST = 10'(NSTREAMS - 1);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_GAP, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {OP_STR, OP_Z, OP_W, OP_FIN} op_t;
  state_t state, state_n;
  op_t op, op_n;
  logic [9:0] stream, stream_n;
  logic [31:0] lfsr, lfsr_n, lfsr_step, seed_mix, adr_n, dat_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic busy_n, done_n, err_n, cyc_n;
  assign lfsr_step = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);
  assign seed_mix = LFSR_INIT ^ seed_i;
  assign stb_o = cyc_o;
  assign we_o = cyc_o;
  assign sel_o = {4{cyc_o}};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      op <= OP_STR;
      stream <= '0;
      lfsr <= LFSR_INIT;
      tcnt <= '0;
      gcnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      cyc_o <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
    end else begin
      state <= state_n;
      op <= op_n;
      stream <= stream_n;
      lfsr <= lfsr_n;
      tcnt <= tcnt_n;
      gcnt <= gcnt_n;
      busy_o <= busy_n;
      done_o <= done_n;
      err_o <= err_n;
      cyc_o <= cyc_n;
      adr_o <= adr_n;
      dat_o <= dat_n;
    end
  end
  always_comb begin
    state_n = state;
    op_n = op;
    stream_n = stream;
    lfsr_n = lfsr;
    tcnt_n = tcnt;
    gcnt_n = gcnt;
    case (state)
      S_IDLE, S_ERR: if (start_i) begin
        state_n = S_WR;
        op_n = OP_STR;
        stream_n = '0;
        lfsr_n = seed_mix == 32'h0 ? 32'h1 : seed_mix;
        tcnt_n = '0;
      end
      S_WR: if (ack_i) begin
        state_n = S_GAP;
        gcnt_n = '0;
        lfsr_n = (op == OP_Z || op == OP_W) ? lfsr_step : lfsr;
      end else begin
        state_n = tcnt == TW'(TIMEOUT - 1) ? S_ERR : S_WR;
        tcnt_n = tcnt + 1'b1;
      end
      S_GAP: if (gcnt != GW'(GAP - 1)) gcnt_n = gcnt + 1'b1;
      else if (op == OP_FIN) state_n = S_DONE;
      else begin
        state_n = S_WR;
        tcnt_n = '0;
        op_n = op == OP_STR ? OP_Z : op == OP_Z ? OP_W : stream == LAST ? OP_FIN : OP_STR;
        stream_n = op != OP_W ? stream : stream == LAST ? 10'd0 : stream + 10'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    cyc_n = state_n == S_WR;
    busy_n = state_n == S_WR || state_n == S_GAP;
    done_n = state_n == S_DONE;
    err_n = state_n == S_ERR;
    adr_n = !cyc_n ? 32'h0 : RAND_ADDR + (op_n == OP_Z ? 32'h8 : op_n == OP_W ? 32'hC : 32'h4);
    dat_n = !cyc_n || op_n == OP_FIN ? 32'h0 :
            op_n == OP_STR ? {22'h0, stream_n} :
            lfsr_n == 32'h0 ? 32'h1 : lfsr_n;
  end
endmodule
